// File: rtl/midway8080_pkg.sv
// Shared constants and FSM encoding for the Midway 8080 video RAM CPU port.
// No logic; no latency.
// No backpressure.
package midway8080_pkg;

    localparam logic [15:0] VRAM_BASE     = 16'h2400;
    localparam logic [15:0] VRAM_LAST     = 16'h3FFF;
    localparam int          VRAM_BYTES    = 7168;
    localparam int          VRAM_COLS     = 224;
    localparam int          BYTES_PER_COL = 32;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_ISSUE = 3'd1,
        ST_RD_DATA  = 3'd2,
        ST_RD_DONE  = 3'd3,
        ST_WR_DONE  = 3'd4
    } cpu_state_e;

endpackage

// File: rtl/midway8080_wr_fifo.sv
// Synchronous write-buffer FIFO holding {ram address, data} entries.
// Latency: a pushed entry is visible at the head on the next cycle.
// Backpressure: full_o/empty_o; callers never push when full or pop when empty.
module midway8080_wr_fifo #(
    parameter int W     = 21,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  logic [W-1:0]             wdata_i,
    input  logic                     pop_i,
    output logic [W-1:0]             rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] cnt_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (cnt_q == LW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign level_o = cnt_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/midway8080_vram_cpu_port.sv
// CPU side of the shared video RAM: buffered writes, blocking reads, scanout first.
// Latency: writes complete same cycle (drain next cycle); in-range reads >=1 cycle.
// Backpressure: cpu_ready held low while the write FIFO is full or the RAM is busy.
module midway8080_vram_cpu_port #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] VRAM_BASE  = midway8080_pkg::VRAM_BASE,
    parameter logic [15:0] VRAM_LAST  = midway8080_pkg::VRAM_LAST,
    parameter int          RAM_AW     = 13
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [15:0]                   cpu_addr,
    input  logic [7:0]                    cpu_wdata,
    input  logic                          cpu_wr,
    input  logic                          cpu_rd,
    output logic [7:0]                    cpu_rdata,
    output logic                          cpu_ready,
    output logic                          cpu_vram_hit,
    input  logic                          scan_req,
    input  logic [RAM_AW-1:0]             scan_addr,
    output logic [7:0]                    scan_data,
    output logic                          scan_valid,
    output logic [RAM_AW-1:0]             ram_addr,
    output logic [7:0]                    ram_wdata,
    output logic                          ram_we,
    input  logic [7:0]                    ram_rdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    import midway8080_pkg::*;

    localparam int EW = RAM_AW + 8;

    cpu_state_e        state_q;
    logic              miss_q;
    logic [7:0]        rdata_q;
    logic              scan_valid_q;
    logic [RAM_AW-1:0] offset;
    logic [EW-1:0]     head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic              rd_issue;
    logic              wr_accept;

    assign cpu_vram_hit = (cpu_addr >= VRAM_BASE) && (cpu_addr <= VRAM_LAST);
    assign offset       = RAM_AW'(cpu_addr - VRAM_BASE);

    // Out-of-range writes complete immediately and never reach the FIFO.
    assign wr_accept = (state_q == ST_IDLE) && cpu_wr && (!cpu_vram_hit || !fifo_full);
    assign fifo_push = wr_accept && cpu_vram_hit;
    assign fifo_pop  = !scan_req && !fifo_empty;
    assign rd_issue  = (state_q == ST_RD_ISSUE) && !scan_req && fifo_empty;

    midway8080_wr_fifo #(
        .W     (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (fifo_push),
        .wdata_i ({offset, cpu_wdata}),
        .pop_i   (fifo_pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    assign ram_addr  = scan_req    ? scan_addr :
                       !fifo_empty ? head[EW-1:8] :
                       rd_issue    ? offset : '0;
    assign ram_wdata = fifo_pop ? head[7:0] : 8'h00;
    assign ram_we    = fifo_pop;

    assign scan_valid = scan_valid_q;
    assign scan_data  = scan_valid_q ? ram_rdata : 8'h00;

    assign cpu_rdata = (state_q == ST_RD_DATA) ? (miss_q ? 8'h00 : ram_rdata) : rdata_q;
    assign cpu_ready = wr_accept || (state_q == ST_RD_DATA);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scan_valid_q <= 1'b0;
        end else begin
            scan_valid_q <= scan_req;
        end
    end

    // Each request level gets exactly one completion; the DONE states wait for it to drop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            miss_q  <= 1'b0;
            rdata_q <= 8'h00;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cpu_wr) begin
                        if (wr_accept) state_q <= ST_WR_DONE;
                    end else if (cpu_rd) begin
                        miss_q  <= !cpu_vram_hit;
                        state_q <= cpu_vram_hit ? ST_RD_ISSUE : ST_RD_DATA;
                    end
                end
                ST_RD_ISSUE: if (rd_issue) state_q <= ST_RD_DATA;
                ST_RD_DATA: begin
                    rdata_q <= cpu_rdata;
                    state_q <= ST_RD_DONE;
                end
                ST_RD_DONE:  if (!cpu_rd) state_q <= ST_IDLE;
                ST_WR_DONE:  if (!cpu_wr) state_q <= ST_IDLE;
                default:     state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_midway8080_vram_cpu_port.sv
// Bench for midway8080_vram_cpu_port: RAM model, write scoreboard, scanout and
// read-data checks against bench-side expectations.
module tb_midway8080_vram_cpu_port;

    localparam int AW = 13;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [15:0]   cpu_addr;
    logic [7:0]    cpu_wdata;
    logic          cpu_wr;
    logic          cpu_rd;
    logic [7:0]    cpu_rdata;
    logic          cpu_ready;
    logic          cpu_vram_hit;
    logic          scan_req;
    logic [AW-1:0] scan_addr;
    logic [7:0]    scan_data;
    logic          scan_valid;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_wdata;
    logic          ram_we;
    logic [7:0]    ram_rdata;
    logic [2:0]    fifo_level;

    always #5 clk = ~clk;

    midway8080_vram_cpu_port dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_wr       (cpu_wr),
        .cpu_rd       (cpu_rd),
        .cpu_rdata    (cpu_rdata),
        .cpu_ready    (cpu_ready),
        .cpu_vram_hit (cpu_vram_hit),
        .scan_req     (scan_req),
        .scan_addr    (scan_addr),
        .scan_data    (scan_data),
        .scan_valid   (scan_valid),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_we       (ram_we),
        .ram_rdata    (ram_rdata),
        .fifo_level   (fifo_level)
    );

    // Synchronous single-port RAM, read-before-write, one-cycle read latency.
    logic [7:0] mem [0:8191];
    logic [7:0] exp_mem [0:8191];
    always @(posedge clk) begin
        ram_rdata <= mem[ram_addr];
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    typedef struct packed {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } wr_t;
    wr_t wr_q[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Per-cycle monitor: scanout timing/data, single-cycle ready, write scoreboard.
    logic       scan_pend = 1'b0;
    logic       ready_prev = 1'b0;
    logic [7:0] scan_exp = 8'h00;
    always @(negedge clk) begin
        if (!reset_n) begin
            scan_pend  = 1'b0;
            ready_prev = 1'b0;
        end else begin
            check("scan_valid", {31'd0, scan_valid}, {31'd0, scan_pend});
            if (scan_pend) check("scan_data", {24'd0, scan_data}, {24'd0, scan_exp});
            if (ready_prev) check("ready_twice", {31'd0, cpu_ready}, 32'd0);
            if (scan_req) check("we_during_scan", {31'd0, ram_we}, 32'd0);
            if (ram_we) begin
                wr_t e;
                if (wr_q.size() == 0) begin
                    check("unexpected_we", {31'd0, ram_we}, 32'd0);
                end else begin
                    e = wr_q.pop_front();
                    check("we_addr", {19'd0, ram_addr}, {19'd0, e.a});
                    check("we_data", {24'd0, ram_wdata}, {24'd0, e.d});
                end
            end
            scan_pend  = scan_req;
            scan_exp   = mem[scan_addr];
            ready_prev = cpu_ready;
        end
    end

    function automatic bit in_vram(input logic [15:0] a);
        return (a >= 16'h2400) && (a <= 16'h3FFF);
    endfunction

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, output int lat);
        wr_t e;
        bit  done;
        @(posedge clk); #1;
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_wr    = 1'b1;
        if (in_vram(a)) begin
            e.a = AW'(a - 16'h2400);
            e.d = d;
            wr_q.push_back(e);
            exp_mem[e.a] = d;
        end
        lat  = 0;
        done = 1'b0;
        while (!done && lat < 60) begin
            @(negedge clk);
            if (cpu_ready) done = 1'b1;
            else lat++;
        end
        if (!done) check("wr_timeout", {31'd0, cpu_ready}, 32'd1);
        @(posedge clk); #1;
        cpu_wr = 1'b0;
    endtask

    task automatic cpu_read(input logic [15:0] a, input logic [7:0] exp, input string tag,
                            output int lat);
        bit done;
        @(posedge clk); #1;
        cpu_addr = a;
        cpu_rd   = 1'b1;
        lat  = 0;
        done = 1'b0;
        while (!done && lat < 60) begin
            @(negedge clk);
            if (cpu_ready) done = 1'b1;
            else lat++;
        end
        if (!done) check("rd_timeout", {31'd0, cpu_ready}, 32'd1);
        else check(tag, {24'd0, cpu_rdata}, {24'd0, exp});
        @(posedge clk); #1;
        cpu_rd = 1'b0;
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((wr_q.size() != 0 || fifo_level != 3'd0) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("drain_level", {29'd0, fifo_level}, 32'd0);
        check("drain_sb", wr_q.size(), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    int lat;

    initial begin
        for (int i = 0; i < 8192; i++) begin
            mem[i]     = 8'h00;
            exp_mem[i] = 8'h00;
        end
        reset_n   = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_wdata = 8'h00;
        cpu_wr    = 1'b0;
        cpu_rd    = 1'b0;
        scan_req  = 1'b0;
        scan_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'd0, cpu_ready}, 32'd0);
        check("rst_we", {31'd0, ram_we}, 32'd0);
        check("rst_level", {29'd0, fifo_level}, 32'd0);
        check("rst_scan_valid", {31'd0, scan_valid}, 32'd0);
        check("rst_rdata", {24'd0, cpu_rdata}, 32'd0);
        reset_n = 1'b1;

        // 1: write lands in RAM one cycle after same-cycle completion.
        cpu_write(16'h2400, 8'hA5, lat);
        check("t1_wr_lat", lat, 32'd0);
        @(negedge clk);
        check("t1_we", {31'd0, ram_we}, 32'd1);
        check("t1_addr", {19'd0, ram_addr}, 32'h0000);
        check("t1_data", {24'd0, ram_wdata}, 32'hA5);
        wait_drain();

        // 2: buffered write must drain before the read of the same byte.
        @(posedge clk); #1;
        scan_req  = 1'b1;
        scan_addr = AW'(13'h0100);
        cpu_write(16'h3FFF, 8'h3C, lat);
        fork
            cpu_read(16'h3FFF, 8'h3C, "t2_rd_data", lat);
            begin
                repeat (3) @(posedge clk);
                #1 scan_req = 1'b0;
            end
        join
        wait_drain();

        // 3: continuous scanout fills the FIFO; fifth write stalls until it drops.
        fork
            begin
                @(posedge clk); #1;
                scan_req  = 1'b1;
                scan_addr = AW'(13'h0200);
                repeat (10) @(posedge clk);
                #1 scan_req = 1'b0;
            end
            begin
                for (int i = 0; i < 4; i++) cpu_write(16'h2500 + 16'(i), 8'h10 + 8'(i), lat);
                check("t3_level_full", {29'd0, fifo_level}, 32'd4);
                cpu_write(16'h2504, 8'h14, lat);
                check("t3_fifth_stalled", {31'd0, lat > 0}, 32'd1);
            end
        join
        wait_drain();

        // 4: out-of-range read returns zero after one cycle; out-of-range write is dropped.
        cpu_read(16'h2000, 8'h00, "t4_rd_data", lat);
        check("t4_rd_lat", lat, 32'd1);
        cpu_write(16'h4000, 8'hEE, lat);
        check("t4_wr_lat", lat, 32'd0);
        repeat (3) @(negedge clk);

        // 5: scanout every other cycle interleaved with back-to-back writes.
        fork
            for (int i = 0; i < 24; i++) begin
                @(posedge clk); #1;
                scan_req  = (i % 2 == 0);
                scan_addr = AW'(i * 37);
            end
            for (int i = 0; i < 6; i++) cpu_write(16'h2800 + 16'(i * 33), 8'($urandom), lat);
        join
        @(posedge clk); #1 scan_req = 1'b0;
        wait_drain();
        cpu_read(16'h2800 + 16'(5 * 33), exp_mem[13'h0400 + 13'(5 * 33)], "t5_rd_back", lat);

        // 6: reset with buffered writes flushes them.
        @(posedge clk); #1;
        scan_req = 1'b1;
        for (int i = 0; i < 3; i++) cpu_write(16'h3000 + 16'(i), 8'h60 + 8'(i), lat);
        check("t6_level", {29'd0, fifo_level}, 32'd3);
        @(posedge clk); #1;
        reset_n  = 1'b0;
        scan_req = 1'b0;
        wr_q.delete();
        #1;
        check("t6_rst_we", {31'd0, ram_we}, 32'd0);
        check("t6_rst_level", {29'd0, fifo_level}, 32'd0);
        check("t6_rst_ready", {31'd0, cpu_ready}, 32'd0);
        check("t6_rst_scan_valid", {31'd0, scan_valid}, 32'd0);
        check("t6_rst_addr", {19'd0, ram_addr}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        check("t6_post_level", {29'd0, fifo_level}, 32'd0);
        cpu_read(16'h3000, 8'h00, "t6_lost_write", lat);

        wait_drain();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
